uart_cmd_host: RTL and testbench
================================

# uart_cmd_host

Command initiator for the UART register/ALU command protocol. It accepts one high-level request (register write, register read, ALU with operands, ALU without operands) and serialises it into the framed byte sequence the system controller expects. It drives those bytes into a UART transmitter through its valid/busy interface and collects the response bytes from a UART receiver. It sits on the host side of the serial link, in the same single clock domain as its UART pair.

## Interface
- `TIMEOUT_CYCLES`, default 4096: CLK cycles allowed in response wait before a timeout is declared.
- `CLK`  in  1  block clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  request present.
- `cmd_ready`  out  1  block idle and able to accept a request; acceptance when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  request type: 0 = WR, 1 = RD, 2 = ALU_OP, 3 = ALU_NOP.
- `cmd_addr`  in  4  register address (WR, RD).
- `cmd_wdata`  in  8  write data (WR).
- `cmd_opa`, `cmd_opb`  in  8 each  ALU operands (ALU_OP).
- `cmd_fun`  in  4  ALU function (ALU_OP, ALU_NOP).
- `tx_data`  out  8  byte to transmit.
- `tx_valid`  out  1  byte request to the UART transmitter.
- `tx_busy`  in  1  UART transmitter busy (already synchronised to CLK).
- `rx_data`  in  8  received byte.
- `rx_valid`  in  1  one-cycle strobe marking a valid `rx_data`.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_data`  out  16  response payload; held until the next completion.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: the response timed out.

## Operation
- **Frame contents**, bytes sent in the order listed:
  - WR: 0xAA, `{4'h0, addr}`, wdata.
  - RD: 0xBB, `{4'h0, addr}`.
  - ALU_OP: 0xCC, opa, opb, `{4'h0, fun}`.
  - ALU_NOP: 0xDD, `{4'h0, fun}`.
- **Expected response bytes:** WR 0, RD 1, ALU_OP/ALU_NOP 2 (LSB first).
- **Request capture:** all request fields are registered on acceptance. Input changes after acceptance have no effect.
- **FSM states:** IDLE, SEND, DRAIN, WAIT_RSP, DONE.
  - IDLE → SEND on acceptance; byte index = 0.
  - SEND: `tx_valid = 1` and `tx_data = frame[idx]`. When `tx_busy = 1` is sampled, go to DRAIN.
  - DRAIN: wait for `tx_busy = 0`. Then, if more bytes remain: `idx++` and go to SEND. Otherwise go to WAIT_RSP if the op expects response bytes, else go to DONE.
  - WAIT_RSP: each `rx_valid` stores `rx_data` into the next response byte (byte 0 → `rsp_data[7:0]`, byte 1 → `rsp_data[15:8]`). After the last expected byte, go to DONE with `rsp_timeout = 0`. If the timer reaches `TIMEOUT_CYCLES` first, go to DONE with `rsp_timeout = 1`; bytes already received are kept.
  - DONE: `rsp_valid = 1` for exactly one cycle, then IDLE.
- **Response width rules:**
  - RD: `rsp_data[15:8] = 0`.
  - WR: `rsp_data = 0`, `rsp_timeout = 0`.
  - `rsp_data` is cleared at acceptance.
- **Stray and ignored inputs:**
  - `rx_valid` outside WAIT_RSP is ignored.
  - `cmd_valid` while `cmd_ready = 0` is ignored.
- **Mid-operation reset:** `RST` asserted in any state aborts the frame. No partial `rsp_valid` is emitted.

## Timing
- **Reset values** (next edge with `RST = 1`): state IDLE, `cmd_ready = 1`, `tx_valid = 0`, `tx_data = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_timeout = 0`, timer 0, index 0.
- **Acceptance to first byte:** `tx_valid` rises on the cycle after acceptance. `cmd_ready` falls the same cycle.
- **TX handshake:**
  - `tx_valid` is held until `tx_busy` is seen high, then drops on the next edge.
  - The next byte is presented no earlier than the cycle after `tx_busy` is sampled low.
  - Minimum time per byte: 2 cycles plus the busy time.
- **Response timer:**
  - Cleared on entry to WAIT_RSP. Increments every cycle in WAIT_RSP; does not restart on received bytes.
  - Timeout fires when the count equals `TIMEOUT_CYCLES − 1` and the frame is still incomplete.
  - `rx_valid` arriving on the timeout cycle counts as received and wins over the timeout.
- **Completion timing:**
  - `rsp_valid` appears one cycle after the last response byte, or after the timeout.
  - For WR, `rsp_valid` appears one cycle after the final DRAIN exit.
  - `cmd_ready` returns high the cycle after `rsp_valid`.

## Structure
- **Shared package `uart_cmd_pkg`:** opcode frame constants (0xAA, 0xBB, 0xCC, 0xDD), the `cmd_op` encodings, FSM state encoding, and per-op byte-count / response-count constants. The future system-controller testbench reuses this package.
- **Sub-module `cmd_rsp_timer`:** clear/enable/expired counter, width `$clog2(TIMEOUT_CYCLES)`.
- Frame byte selection is a combinational mux on (op, idx) inside the top module.

## Test plan
- **WR:** request WR addr = 3, wdata = 0x5A; bench busy model asserts `tx_busy` 2 cycles after `tx_valid` for 10 cycles → bytes AA, 03, 5A emitted in order; `rsp_valid` with `rsp_data = 0x0000`, `rsp_timeout = 0`.
- **RD:** request RD addr = 2; after the frame, drive `rx_data = 0x81` → `rsp_data = 0x0081`, `rsp_timeout = 0`.
- **ALU_OP:** opa = 0x10, opb = 0x20, fun = 0; rx bytes 0x30, 0x00 → frame CC, 10, 20, 00; `rsp_data = 0x0030`. ALU_NOP with fun = 1 → frame DD, 01.
- **Timeout:** `TIMEOUT_CYCLES = 16`, RD with no rx → `rsp_valid` with `rsp_timeout = 1` exactly 16 cycles after WAIT_RSP entry. ALU with only byte 0xAB received → `rsp_data = 0x00AB`, timeout = 1.
- **Ignored inputs:** stray `rx_valid` while IDLE and during SEND → no state change. `cmd_valid` while busy → second request not captured; `cmd_ready` stays 0.
- **Mid-frame reset:** `RST` asserted during DRAIN of byte 2 → all outputs at reset values next cycle; no `rsp_valid`; the next request frames correctly.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART register/ALU command protocol: frame headers,
// request encodings, host FSM states and per-op frame/response lengths.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    OP_WR      = 2'd0,
    OP_RD      = 2'd1,
    OP_ALU     = 2'd2,
    OP_ALU_NOP = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_DRAIN,
    ST_WAIT_RSP,
    ST_DONE
  } host_state_e;

  localparam logic [7:0] HDR_WR      = 8'hAA;
  localparam logic [7:0] HDR_RD      = 8'hBB;
  localparam logic [7:0] HDR_ALU     = 8'hCC;
  localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

  localparam int unsigned FRAME_LEN_WR      = 3;
  localparam int unsigned FRAME_LEN_RD      = 2;
  localparam int unsigned FRAME_LEN_ALU     = 4;
  localparam int unsigned FRAME_LEN_ALU_NOP = 2;

  localparam int unsigned RSP_LEN_WR      = 0;
  localparam int unsigned RSP_LEN_RD      = 1;
  localparam int unsigned RSP_LEN_ALU     = 2;
  localparam int unsigned RSP_LEN_ALU_NOP = 2;

  // Index of the final frame byte for a given request type.
  function automatic logic [1:0] last_idx(cmd_op_e op);
    case (op)
      OP_WR:   return 2'(FRAME_LEN_WR - 1);
      OP_RD:   return 2'(FRAME_LEN_RD - 1);
      OP_ALU:  return 2'(FRAME_LEN_ALU - 1);
      default: return 2'(FRAME_LEN_ALU_NOP - 1);
    endcase
  endfunction

  function automatic logic [1:0] rsp_len(cmd_op_e op);
    case (op)
      OP_WR:   return 2'(RSP_LEN_WR);
      OP_RD:   return 2'(RSP_LEN_RD);
      OP_ALU:  return 2'(RSP_LEN_ALU);
      default: return 2'(RSP_LEN_ALU_NOP);
    endcase
  endfunction

endpackage

// File: rtl/cmd_rsp_timer.sv
// Response-wait timer: cleared while inactive, counts while enabled, and
// flags expiry once the count reaches TIMEOUT_CYCLES-1.
module cmd_rsp_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/uart_cmd_host.sv
// Host-side command initiator: frames one request into UART bytes via a
// valid/busy handshake and collects the response bytes from the receiver.
module uart_cmd_host
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [7:0]  cmd_wdata,
  input  logic [7:0]  cmd_opa,
  input  logic [7:0]  cmd_opb,
  input  logic [3:0]  cmd_fun,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_timeout
);

  host_state_e state, state_next;

  cmd_op_e    op_q;
  logic [3:0] addr_q, fun_q;
  logic [7:0] wdata_q, opa_q, opb_q;
  logic [1:0] idx, rx_cnt;
  logic [7:0] frame_byte;
  logic       accept, last_byte, last_rx, rx_take, expired;
  logic       in_wait;

  assign accept    = cmd_valid && (state == ST_IDLE);
  assign last_byte = (idx == last_idx(op_q));
  assign last_rx   = (rx_cnt == rsp_len(op_q) - 2'd1);
  assign in_wait   = (state == ST_WAIT_RSP);
  assign rx_take   = in_wait && rx_valid;

  cmd_rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (CLK),
    .rst    (RST),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  always_comb begin
    frame_byte = '0;
    case (op_q)
      OP_WR:
        case (idx)
          2'd0:    frame_byte = HDR_WR;
          2'd1:    frame_byte = {4'h0, addr_q};
          default: frame_byte = wdata_q;
        endcase
      OP_RD:
        frame_byte = (idx == 2'd0) ? HDR_RD : {4'h0, addr_q};
      OP_ALU:
        case (idx)
          2'd0:    frame_byte = HDR_ALU;
          2'd1:    frame_byte = opa_q;
          2'd2:    frame_byte = opb_q;
          default: frame_byte = {4'h0, fun_q};
        endcase
      default:
        frame_byte = (idx == 2'd0) ? HDR_ALU_NOP : {4'h0, fun_q};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_next = ST_SEND;
      ST_SEND:  if (tx_busy) state_next = ST_DRAIN;
      ST_DRAIN:
        if (!tx_busy) begin
          if (!last_byte)                  state_next = ST_SEND;
          else if (rsp_len(op_q) == 2'd0)  state_next = ST_DONE;
          else                             state_next = ST_WAIT_RSP;
        end
      // A byte landing on the expiry cycle completes the frame first.
      ST_WAIT_RSP: if ((rx_valid && last_rx) || expired) state_next = ST_DONE;
      ST_DONE:     state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    tx_valid  = (state == ST_SEND);
    tx_data   = tx_valid ? frame_byte : '0;
    rsp_valid = (state == ST_DONE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q        <= OP_WR;
      addr_q      <= '0;
      wdata_q     <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      fun_q       <= '0;
      idx         <= '0;
      rx_cnt      <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        op_q        <= cmd_op_e'(cmd_op);
        addr_q      <= cmd_addr;
        wdata_q     <= cmd_wdata;
        opa_q       <= cmd_opa;
        opb_q       <= cmd_opb;
        fun_q       <= cmd_fun;
        idx         <= '0;
        rx_cnt      <= '0;
        rsp_data    <= '0;
        rsp_timeout <= 1'b0;
      end
      if ((state == ST_DRAIN) && !tx_busy && !last_byte) idx <= idx + 2'd1;
      if (rx_take) begin
        if (rx_cnt == 2'd0) rsp_data[7:0]  <= rx_data;
        else                rsp_data[15:8] <= rx_data;
        rx_cnt <= rx_cnt + 2'd1;
      end
      if (in_wait && expired && !(rx_valid && last_rx)) rsp_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host: busy-model transmitter, byte and response
// scoreboards, timeout latency, ignored inputs and mid-frame reset.
module tb_uart_cmd_host;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic [7:0]  cmd_opa = '0;
  logic [7:0]  cmd_opb = '0;
  logic [3:0]  cmd_fun = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_timeout;

  uart_cmd_host #(
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_opa    (cmd_opa),
    .cmd_opb    (cmd_opb),
    .cmd_fun    (cmd_fun),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0]  exp_tx[$];
  logic [15:0] exp_rsp_data[$];
  logic        exp_rsp_to[$];

  int          fall_cyc = 0;
  int          rsp_count = 0;
  int          rsp_base = 0;
  int          rsp_cyc = 0;
  logic [15:0] rsp_d = '0;
  logic        rsp_to = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Transmitter model: busy rises 2 cycles after tx_valid and stays 10 cycles.
  initial begin
    int dly = 0;
    int bcnt = 0;
    forever begin
      @(posedge CLK); #1;
      if (RST) begin
        tx_busy = 1'b0; dly = 0; bcnt = 0;
      end else if (tx_busy) begin
        if (bcnt == 10) check("tx_valid_drop", 32'(tx_valid), 32'd0);
        bcnt--;
        if (bcnt == 0) begin
          tx_busy = 1'b0;
          fall_cyc = cyc;
        end
      end else if (tx_valid) begin
        if (dly == 2) begin
          if (exp_tx.size() == 0) check("tx_extra_byte", 32'(exp_tx.size()), 32'd1);
          else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          tx_busy = 1'b1; bcnt = 10; dly = 0;
        end else begin
          dly++;
        end
      end else begin
        dly = 0;
      end
    end
  end

  // Response monitor: captures each completion and checks the pulse is single-cycle.
  initial begin
    forever begin
      @(posedge CLK); #1;
      if (rsp_valid) begin
        rsp_count++;
        rsp_d   = rsp_data;
        rsp_to  = rsp_timeout;
        rsp_cyc = cyc;
        @(posedge CLK); #1;
        check("rsp_pulse_width", 32'(rsp_valid), 32'd0);
        check("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wdata,
                       input logic [7:0] opa, input logic [7:0] opb, input logic [3:0] fun,
                       input logic [15:0] rdata, input logic to);
    @(negedge CLK);
    case (op)
      2'd0: begin exp_tx.push_back(8'hAA); exp_tx.push_back({4'h0, addr}); exp_tx.push_back(wdata); end
      2'd1: begin exp_tx.push_back(8'hBB); exp_tx.push_back({4'h0, addr}); end
      2'd2: begin
        exp_tx.push_back(8'hCC); exp_tx.push_back(opa);
        exp_tx.push_back(opb);   exp_tx.push_back({4'h0, fun});
      end
      default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, fun}); end
    endcase
    exp_rsp_data.push_back(rdata);
    exp_rsp_to.push_back(to);
    rsp_base = rsp_count;
    cmd_op = op; cmd_addr = addr; cmd_wdata = wdata;
    cmd_opa = opa; cmd_opb = opb; cmd_fun = fun;
    cmd_valid = 1'b1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge CLK);
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_addr = ~addr; cmd_wdata = ~wdata;
    cmd_opa = ~opa; cmd_opb = ~opb; cmd_fun = ~fun;
    check("tx_valid_after_accept", 32'(tx_valid), 32'd1);
    check("cmd_ready_after_accept", 32'(cmd_ready), 32'd0);
  endtask

  task automatic wait_frame_sent();
    int n = 0;
    while ((exp_tx.size() != 0 || tx_busy) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("frame_sent_in_time", 32'(n < 400), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge CLK);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge CLK);
    rx_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input int exp_lat);
    int n = 0;
    logic [15:0] ed;
    logic        et;
    while (rsp_count == rsp_base && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_rsp_seen"}, 32'(rsp_count - rsp_base), 32'd1);
    ed = exp_rsp_data.pop_front();
    et = exp_rsp_to.pop_front();
    check({tag, "_rsp_data"}, 32'(rsp_d), 32'(ed));
    check({tag, "_rsp_timeout"}, 32'(rsp_to), 32'(et));
    if (exp_lat >= 0) check({tag, "_rsp_latency"}, 32'(rsp_cyc - fall_cyc), 32'(exp_lat));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge CLK);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    RST = 1'b0;

    // WR: completes one cycle after the final busy release
    issue(2'd0, 4'd3, 8'h5A, 8'h00, 8'h00, 4'h0, 16'h0000, 1'b0);
    wait_frame_sent();
    expect_rsp("wr", 1);

    // RD with a stray rx byte during SEND and a second request while busy
    issue(2'd1, 4'd2, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0081, 1'b0);
    send_rx(8'hEE);
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_addr = 4'hF; cmd_wdata = 8'h11;
    repeat (4) begin
      @(negedge CLK);
      check("cmd_ready_while_busy", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    wait_frame_sent();
    send_rx(8'h81);
    expect_rsp("rd", -1);

    issue(2'd2, 4'd0, 8'h00, 8'h10, 8'h20, 4'h0, 16'h0030, 1'b0);
    wait_frame_sent();
    send_rx(8'h30);
    send_rx(8'h00);
    expect_rsp("alu", -1);

    issue(2'd3, 4'd0, 8'h00, 8'h00, 8'h00, 4'h1, 16'h1234, 1'b0);
    wait_frame_sent();
    send_rx(8'h34);
    send_rx(8'h12);
    expect_rsp("alu_nop", -1);

    // Timeouts: rsp_valid 16 cycles after WAIT_RSP entry (entry = fall + 1)
    issue(2'd1, 4'd7, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 1'b1);
    wait_frame_sent();
    expect_rsp("rd_timeout", 17);

    issue(2'd2, 4'd0, 8'h00, 8'h01, 8'h02, 4'h5, 16'h00AB, 1'b1);
    wait_frame_sent();
    send_rx(8'hAB);
    expect_rsp("alu_timeout", 17);

    rsp_base = rsp_count;
    send_rx(8'h55);
    repeat (3) @(negedge CLK);
    check("idle_stray_cmd_ready", 32'(cmd_ready), 32'd1);
    check("idle_stray_tx_valid", 32'(tx_valid), 32'd0);
    check("idle_stray_no_rsp", 32'(rsp_count - rsp_base), 32'd0);
    check("idle_stray_rsp_held", 32'(rsp_data), 32'h00AB);

    // Reset while draining the second byte of a WR frame
    issue(2'd0, 4'd9, 8'hC3, 8'h00, 8'h00, 4'h0, 16'h0000, 1'b0);
    n = 0;
    while (exp_tx.size() > 1 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check("second_byte_sent", 32'(exp_tx.size()), 32'd1);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_rsp_data", 32'(rsp_data), 32'd0);
    check("midrst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    RST = 1'b0;
    exp_tx.delete();
    exp_rsp_data.delete();
    exp_rsp_to.delete();
    rsp_base = rsp_count;
    repeat (30) @(negedge CLK);
    check("midrst_no_rsp", 32'(rsp_count - rsp_base), 32'd0);
    check("midrst_idle_tx", 32'(tx_valid), 32'd0);

    issue(2'd2, 4'd0, 8'h00, 8'h44, 8'h55, 4'h6, 16'h0099, 1'b0);
    wait_frame_sent();
    send_rx(8'h99);
    send_rx(8'h00);
    expect_rsp("post_rst_alu", -1);

    check("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
